nios2_keypio_edge: RTL

NIOS2_KEYPIO_EDGE -- requirements
Module: nios2_keypio_edge

---
 rtl/nios2_keypio_edge.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/nios2_keypio_edge.sv
// nios2_keypio_edge: Avalon-MM key/PIO input port with edge capture and interrupt.
//
// Each in_port bit passes through a 2-flop synchroniser and, optionally, a
// debounce filter. Edges on the conditioned input are latched into an
// edge-capture register (write-1-to-clear). The masked captures drive a
// registered level interrupt.
//
// Optional feature: define KEYPIO_DEBOUNCE_EN to insert a per-bit debounce
// filter between the synchroniser and the edge detector.
//
// Register map (word address):
//   0 data      RO   conditioned input
//   1 reserved  reads 0, writes ignored
//   2 irq mask  RW   WIDTH bits
//   3 capture   R/W1C
//
// Ports:
//   clk, reset_n   clock (rising edge), asynchronous active-low reset
//   address        word address
//   chipselect     slave select, qualifies writes
//   write_n        active-low write strobe
//   writedata      write data (bits above WIDTH ignored)
//   in_port        asynchronous external inputs
//   readdata       registered read data, 1-cycle latency, zero-extended
//   irq            registered level interrupt
module nios2_keypio_edge #(
    parameter int unsigned      WIDTH           = 3,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE = 2'd3;

    logic [WIDTH-1:0]  sync_q1;
    logic [WIDTH-1:0]  sync_q2;
    logic [WIDTH-1:0]  cond_in;
    logic [WIDTH-1:0]  cond_prev;
    logic [WIDTH-1:0]  edge_det;
    logic [WIDTH-1:0]  capture;
    logic [WIDTH-1:0]  mask;
    logic [WIDTH-1:0]  capture_clr;
    logic [DATA_W-1:0] read_mux;
    logic              wr_en;

    // Two-flop synchroniser for the asynchronous key inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= RESET_LEVEL;
            sync_q2 <= RESET_LEVEL;
        end else begin
            sync_q1 <= in_port;
            sync_q2 <= sync_q1;
        end
    end

`ifdef KEYPIO_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt [WIDTH];
    logic [WIDTH-1:0] db_filt;

    // Filtered bit follows the synchronised bit only after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement; any agreement restarts the count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_filt <= RESET_LEVEL;
            for (int i = 0; i < int'(WIDTH); i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync_q2[i] != db_filt[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_filt[i] <= sync_q2[i];
                        db_cnt[i]  <= '0;
                    end else begin
                        db_cnt[i]  <= db_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign cond_in = db_filt;
`else
    logic [CNT_W-1:0] unused_db_cycles;
    assign unused_db_cycles = CNT_W'(DEBOUNCE_CYCLES);
    assign cond_in = sync_q2;
`endif

    // Upper writedata bits carry no state when WIDTH < 32
    if (WIDTH < DATA_W) begin : g_wd_unused
        logic unused_wd_hi;
        assign unused_wd_hi = ^writedata[DATA_W-1:WIDTH];
    end

    // Delayed copy of the conditioned input for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_prev <= RESET_LEVEL;
        end else begin
            cond_prev <= cond_in;
        end
    end

    // Edge selection: 0 rising, 2 any, otherwise falling
    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = cond_in & ~cond_prev;
            2:       edge_det = cond_in ^ cond_prev;
            default: edge_det = ~cond_in & cond_prev;
        endcase
    end

    assign wr_en       = chipselect & ~write_n;
    assign capture_clr = (wr_en && (address == ADDR_CAPTURE)) ? writedata[WIDTH-1:0] : '0;

    // Capture register; a simultaneous new edge overrides the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture <= '0;
        end else begin
            capture <= (capture & ~capture_clr) | edge_det;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= '0;
        end else if (wr_en && (address == ADDR_MASK)) begin
            mask <= writedata[WIDTH-1:0];
        end
    end

    // Read mux; unmapped/reserved addresses read zero
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:    read_mux = DATA_W'(cond_in);
            ADDR_MASK:    read_mux = DATA_W'(mask);
            ADDR_CAPTURE: read_mux = DATA_W'(capture);
            default:      read_mux = '0;
        endcase
    end

    // Registered read data and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= read_mux;
            irq      <= |(capture & mask);
        end
    end

endmodule
